// File: rtl/ysyx_041514_pipe_skid_reg.sv
// Two-entry pipeline register with a skid buffer: fully registered handshake
// outputs, one payload per cycle at full throughput, and a synchronous flush.
module ysyx_041514_pipe_skid_reg #(
  parameter int unsigned      WIDTH      = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occ_o
);

  logic             main_valid_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             ready_r;
  logic [1:0]       occ_r;

  logic             main_valid_nxt_s;
  logic             skid_valid_nxt_s;
  logic [WIDTH-1:0] main_data_nxt_s;
  logic [WIDTH-1:0] skid_data_nxt_s;
  logic             up_s;
  logic             dn_s;

  assign up_s = valid_i & ready_r;
  assign dn_s = main_valid_r & ready_i;

  // Next-state selection for the main and skid entries.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    main_data_nxt_s  = main_data_r;
    skid_data_nxt_s  = skid_data_r;
    if (flush_i) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
      main_data_nxt_s  = BUBBLE_VAL;
    end else begin
      case ({main_valid_r, skid_valid_r})
        2'b00: begin
          if (up_s) begin
            main_valid_nxt_s = 1'b1;
            main_data_nxt_s  = data_i;
          end else begin
            main_valid_nxt_s = 1'b0;
          end
        end
        2'b10: begin
          if (dn_s && up_s) begin
            main_data_nxt_s = data_i;
          end else if (dn_s) begin
            main_valid_nxt_s = 1'b0;
            main_data_nxt_s  = BUBBLE_VAL;
          end else if (up_s) begin
            skid_valid_nxt_s = 1'b1;
            skid_data_nxt_s  = data_i;
          end else begin
            main_valid_nxt_s = 1'b1;
          end
        end
        2'b11: begin
          if (dn_s) begin
            main_data_nxt_s  = skid_data_r;
            skid_valid_nxt_s = 1'b0;
          end else begin
            skid_valid_nxt_s = 1'b1;
          end
        end
        default: begin
          // Skid without main is unreachable; fall back to EMPTY.
          main_valid_nxt_s = 1'b0;
          skid_valid_nxt_s = 1'b0;
          main_data_nxt_s  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Entry storage plus registered ready and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_data_r  <= BUBBLE_VAL;
      skid_data_r  <= BUBBLE_VAL;
      ready_r      <= 1'b1;
      occ_r        <= 2'd0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      main_data_r  <= main_data_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      ready_r      <= ~skid_valid_nxt_s;
      occ_r        <= {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
    end
  end

  assign ready_o = ready_r;
  assign valid_o = main_valid_r;
  assign data_o  = main_data_r;
  assign occ_o   = occ_r;

endmodule
